// File: rtl/uart_cmd_rx.sv
// UART 8N1 receiver plus 5-byte command frame parser (AA, CMD, ARGH, ARGL, SUM).
// Latency: cmd_valid/err one clk after the stop-bit sample of the deciding byte.
// Backpressure: none; the serial line cannot be stalled, every result is a one-cycle pulse.
module uart_cmd_rx #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rx,
  output logic        o_cmd_valid,
  output logic [7:0]  o_cmd_code,
  output logic [15:0] o_cmd_arg,
  output logic        o_err,
  output logic [1:0]  o_err_code
);

  // CLK_FREQ/BAUD must be at least 8 so the half-bit wait is meaningful.
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int HALF     = CPB / 2;
  localparam int TO_LIMIT = TIMEOUT_BITS * CPB;
  localparam int CW       = $clog2(CPB + 1);
  localparam int TW       = $clog2(TO_LIMIT + 1);

  typedef enum logic [2:0] {B_IDLE, B_START, B_DATA, B_STOP, B_BRK} bit_st_t;
  typedef enum logic [2:0] {P_HDR, P_CMD, P_ARGH, P_ARGL, P_SUM} par_st_t;

  logic          r_rx_s1, r_rx_s2, r_rx_prev;
  bit_st_t       r_bit_st, w_bit_nxt;
  logic [CW-1:0] r_clk_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  par_st_t       r_par_st, w_par_nxt;
  logic [7:0]    r_sh_cmd, r_sh_argh, r_sh_argl;
  logic [TW-1:0] r_to_cnt;

  logic       w_rx, w_fall, w_tick, w_byte_stb, w_frm_err;
  logic [7:0] w_sum;
  logic       w_to_run, w_timeout, w_cmd_ok, w_sum_bad, w_err_any;
  logic [1:0] w_err_cause;

  assign w_rx   = r_rx_s2;
  assign w_fall = r_rx_prev & ~r_rx_s2;

  // Two-flop synchroniser plus one history flop for falling-edge detection; idles high.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= i_rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  // Bit FSM state register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_bit_st <= B_IDLE;
    else          r_bit_st <= w_bit_nxt;
  end

  // Bit FSM next state; a bad stop bit parks in BRK until the line returns high.
  always_comb begin
    w_bit_nxt = r_bit_st;
    case (r_bit_st)
      B_IDLE:  if (w_fall) w_bit_nxt = B_START;
      B_START: if (w_tick) w_bit_nxt = w_rx ? B_IDLE : B_DATA;
      B_DATA:  if (w_tick && r_bit_idx == 3'd7) w_bit_nxt = B_STOP;
      B_STOP:  if (w_tick) w_bit_nxt = w_rx ? B_IDLE : B_BRK;
      B_BRK:   if (w_rx) w_bit_nxt = B_IDLE;
      default: w_bit_nxt = B_IDLE;
    endcase
  end

  // Bit FSM outputs: sample tick (mid-bit), byte strobe and stop-bit error.
  always_comb begin
    w_tick = 1'b0;
    case (r_bit_st)
      B_START:        w_tick = (r_clk_cnt == CW'(HALF - 1));
      B_DATA, B_STOP: w_tick = (r_clk_cnt == CW'(CPB - 1));
      default:        w_tick = 1'b0;
    endcase
    w_byte_stb = (r_bit_st == B_STOP) && w_tick && w_rx;
    w_frm_err  = (r_bit_st == B_STOP) && w_tick && !w_rx;
  end

  // Bit timing counter, bit index and LSB-first shift register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      if (r_bit_st == B_IDLE || r_bit_st == B_BRK || w_tick) r_clk_cnt <= '0;
      else                                                  r_clk_cnt <= r_clk_cnt + CW'(1);
      if (r_bit_st != B_DATA) r_bit_idx <= '0;
      else if (w_tick)        r_bit_idx <= r_bit_idx + 3'd1;
      if (r_bit_st == B_DATA && w_tick) r_shift <= {w_rx, r_shift[7:1]};
    end
  end

  // Parser state register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_par_st <= P_HDR;
    else          r_par_st <= w_par_nxt;
  end

  // Parser next state; 0xAA mid-frame is plain data, errors abort to header hunt.
  always_comb begin
    w_par_nxt = r_par_st;
    if (w_frm_err || w_timeout) begin
      w_par_nxt = P_HDR;
    end else if (w_byte_stb) begin
      case (r_par_st)
        P_HDR:   if (r_shift == 8'hAA) w_par_nxt = P_CMD;
        P_CMD:   w_par_nxt = P_ARGH;
        P_ARGH:  w_par_nxt = P_ARGL;
        P_ARGL:  w_par_nxt = P_SUM;
        default: w_par_nxt = P_HDR;
      endcase
    end
  end

  // Parser outputs: checksum verdict, timeout detection and error cause.
  always_comb begin
    w_sum       = 8'(r_sh_cmd + r_sh_argh + r_sh_argl);
    w_to_run    = (r_par_st != P_HDR) && (r_bit_st == B_IDLE);
    w_timeout   = w_to_run && (r_to_cnt == TW'(TO_LIMIT - 1)) && !w_byte_stb;
    w_cmd_ok    = (r_par_st == P_SUM) && w_byte_stb && (r_shift == w_sum);
    w_sum_bad   = (r_par_st == P_SUM) && w_byte_stb && (r_shift != w_sum);
    w_err_any   = w_frm_err || w_sum_bad || w_timeout;
    w_err_cause = 2'd3;
    if (w_frm_err)      w_err_cause = 2'd1;
    else if (w_sum_bad) w_err_cause = 2'd2;
  end

  // Shadow registers capture frame fields as they arrive.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sh_cmd  <= '0;
      r_sh_argh <= '0;
      r_sh_argl <= '0;
    end else if (w_byte_stb) begin
      if (r_par_st == P_CMD)  r_sh_cmd  <= r_shift;
      if (r_par_st == P_ARGH) r_sh_argh <= r_shift;
      if (r_par_st == P_ARGL) r_sh_argl <= r_shift;
    end
  end

  // Inter-byte gap counter: runs only while mid-frame with the line idle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                                r_to_cnt <= '0;
    else if (w_byte_stb || !w_to_run || w_timeout) r_to_cnt <= '0;
    else                                         r_to_cnt <= r_to_cnt + TW'(1);
  end

  // Registered results: pulses default low, code/arg/err_code hold between events.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_cmd_valid <= 1'b0;
      o_cmd_code  <= '0;
      o_cmd_arg   <= '0;
      o_err       <= 1'b0;
      o_err_code  <= '0;
    end else begin
      o_cmd_valid <= w_cmd_ok;
      o_err       <= w_err_any;
      if (w_cmd_ok) begin
        o_cmd_code <= r_sh_cmd;
        o_cmd_arg  <= {r_sh_argh, r_sh_argl};
      end
      if (w_err_any) o_err_code <= w_err_cause;
    end
  end

endmodule

// File: doc/uart_cmd_rx.md
Name: uart_cmd_rx

Overview:
- UART command receiver on the MCU link: deserialises 8N1 bytes arriving from the MCU and parses fixed 5-byte command frames.
- Emits decoded command code and argument for the capture and FFT control logic, e.g. capture start and readout-length commands.
- Receive-side counterpart of the FPGA-to-MCU UART transmit path; runs in the same clk domain as the AD/FFT/FIFO chain.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate. CLKS_PER_BIT = CLK_FREQ/BAUD, integer division, must be >= 8.
- TIMEOUT_BITS, 20, maximum idle gap between bytes of one frame, in bit times.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- rx  in  1  asynchronous serial input from MCU; idles high.
- cmd_valid  out  1  one-cycle pulse when a frame passes checksum.
- cmd_code  out  8  command byte; held until the next valid frame.
- cmd_arg  out  16  argument {ARGH, ARGL}; held until the next valid frame.
- err  out  1  one-cycle pulse on framing, checksum or timeout error.
- err_code  out  2  error cause, valid with err: 1 = stop-bit, 2 = checksum, 3 = timeout; holds its last value.

Behaviour:
Reset (rst_n low at a clk edge):
- All outputs go to 0.
- Bit FSM goes to IDLE; parser goes to WAIT_HDR.
- Synchroniser flops are set to 1.
- A reset mid-byte or mid-frame discards all partial data.

Bit receiver:
- rx passes through a 2-flop synchroniser before any use.
- IDLE -> START on a synchronised falling edge (previous sample 1, current sample 0).
- START: wait CLKS_PER_BIT/2 cycles, then resample. If still 0, go to DATA. If 1, treat as a glitch and return to IDLE silently.
- DATA: sample every CLKS_PER_BIT cycles. 8 bits, LSB first.
- STOP: sample after another CLKS_PER_BIT cycles.
  - Sample 1: byte accepted, byte_strobe pulses for one cycle, go to IDLE.
  - Sample 0: err=1, err_code=1, parser forced to WAIT_HDR. The FSM then waits for rx to read 1 before returning to IDLE, so a break condition is not re-triggered as a new start.

Frame parser (driven by byte_strobe):
- Frame format: 0xAA, CMD, ARGH, ARGL, SUM.
- WAIT_HDR:
  - Byte 0xAA -> CMD state.
  - Any other byte is ignored with no error.
- CMD -> ARGH -> ARGL -> SUM, latching each byte into a shadow register.
- SUM state: check SUM == (CMD + ARGH + ARGL) mod 256.
  - Pass: on the following cycle, cmd_code and cmd_arg update and cmd_valid pulses. Total latency is 1 clk after byte_strobe of SUM.
  - Fail: err=1, err_code=2; cmd_code and cmd_arg are unchanged.
  - Either way, return to WAIT_HDR.
- 0xAA received in CMD/ARGH/ARGL/SUM is data, not a resync.

Timeout:
- The counter runs whenever the parser is not in WAIT_HDR and the bit FSM is in IDLE.
- It clears on each byte_strobe.
- On reaching TIMEOUT_BITS*CLKS_PER_BIT: err=1, err_code=3, parser -> WAIT_HDR.
- If timeout and byte_strobe occur in the same cycle, byte_strobe wins: the byte is consumed and no timeout is raised.

Simultaneous events and ordering:
- cmd_valid and err are mutually exclusive in any cycle.
- Back-to-back frames with no idle gap must all be decoded; the parser and bit FSM add no dead cycles between a stop bit and the next start edge.

Test Plan:
- Bench setup: CLK_FREQ=1_600_000, BAUD=100_000, so CLKS_PER_BIT=16.
- Frame AA 01 12 34 47 -> one cmd_valid pulse; cmd_code=0x01, cmd_arg=0x1234; err stays 0. cmd_valid rises 1 clk after the SUM byte's stop-bit sample.
- Frame AA 02 00 10 00 (bad sum; correct is 0x12) -> err pulse, err_code=2, no cmd_valid. cmd_code and cmd_arg keep their previous values 0x01 and 0x1234.
- Byte 0x55 sent with stop bit driven 0, then valid frame AA 03 00 05 08 -> first gives err, err_code=1. The frame then decodes to cmd_code=0x03, cmd_arg=0x0005.
- Garbage 13 37 then AA 04 00 00 04 -> garbage is ignored with no err; cmd_code=0x04, cmd_arg=0x0000.
- AA 05, then idle for 20*16=320 clks -> err, err_code=3. A following AA 05 00 01 06 then decodes normally.
- rx low pulse of 4 clks -> no byte_strobe, no err. Also: assert rst_n=0 mid-ARGH byte -> outputs cleared; the next full frame decodes correctly.
